// File: rtl/sisc_mem_pkg.sv
// Shared encodings and default sizes for the SISC memory arbiter.
// Used by mem_arb and mem_arb_pick; holds no logic.
package sisc_mem_pkg;

  localparam int ADDR_W_DEF  = 16;
  localparam int DATA_W_DEF  = 32;
  localparam int MEM_LAT_DEF = 2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef logic owner_t;
  localparam owner_t OWN_IF = 1'b0;
  localparam owner_t OWN_DM = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational IF/DM winner select; zero latency, no backpressure of its own.
// MEM_ARB_RR_EN: ties go to the requester not granted last, otherwise DM always wins.
module mem_arb_pick
  import sisc_mem_pkg::*;
(
  input  logic   if_req,
  input  logic   dm_req,
`ifdef MEM_ARB_RR_EN
  input  owner_t last_owner,
`endif
  output logic   any_req,
  output owner_t owner
);

  always_comb begin
    any_req = if_req | dm_req;
    owner   = dm_req ? OWN_DM : OWN_IF;
`ifdef MEM_ARB_RR_EN
    if (if_req && dm_req) begin
      owner = (last_owner == OWN_IF) ? OWN_DM : OWN_IF;
    end
`else
`endif
  end

endmodule

// File: rtl/mem_arb.sv
// Single-port memory arbiter for SISC fetch (IF) and data (DM) requesters; optional MEM_ARB_RR_EN.
// Latency: gnt one cycle after the request is sampled, rvalid MEM_LAT cycles later; requests wait while busy.
module mem_arb
  import sisc_mem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MEM_LAT = MEM_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  owner_t            owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              any_req;
  owner_t            pick_owner;
  logic              in_access, in_done;

`ifdef MEM_ARB_RR_EN
  owner_t last_owner_q, last_owner_d;
`endif

  mem_arb_pick u_pick (
    .if_req     (if_req),
    .dm_req     (dm_req),
`ifdef MEM_ARB_RR_EN
    .last_owner (last_owner_q),
`endif
    .any_req    (any_req),
    .owner      (pick_owner)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
`ifdef MEM_ARB_RR_EN
    last_owner_d = last_owner_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          owner_d = pick_owner;
          we_d    = (pick_owner == OWN_DM) ? dm_we : 1'b0;
          addr_d  = (pick_owner == OWN_DM) ? dm_addr : if_addr;
          wdata_d = (pick_owner == OWN_DM) ? dm_wdata : '0;
          state_d = ST_ACCESS;
`ifdef MEM_ARB_RR_EN
          last_owner_d = pick_owner;
`endif
        end
      end
      ST_ACCESS: begin
        cnt_d   = CNT_W'(MEM_LAT - 1);
        state_d = (MEM_LAT == 1) ? ST_DONE : ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Read data lands on the edge that enters DONE, alongside rvalid rising.
    if (state_d == ST_DONE && !we_q) begin
      if (owner_q == OWN_DM) dm_rdata_d = mem_rdata;
      else                   if_rdata_d = mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      owner_q    <= OWN_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_owner_q <= OWN_IF;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
`ifdef MEM_ARB_RR_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  assign in_access = (state_q == ST_ACCESS);
  assign in_done   = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign mem_en    = in_access;
  assign mem_we    = in_access & we_q;
  assign mem_addr  = in_access ? addr_q : '0;
  assign mem_wdata = in_access ? wdata_q : '0;
  assign if_gnt    = in_access & (owner_q == OWN_IF);
  assign dm_gnt    = in_access & (owner_q == OWN_DM);
  assign if_rvalid = in_done & (owner_q == OWN_IF);
  assign dm_rvalid = in_done & (owner_q == OWN_DM);
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb at MEM_LAT = 2: directed steps plus random transactions against a
// transaction-level model (grant order, cycle offsets, reference memory contents).
module tb_mem_arb;

  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int LAT = 2;
  localparam int RUN = 2 * LAT + 6;

  logic          clk, rst_f;
  logic          if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0] dmem    [256];
  logic [DW-1:0] ref_mem [256];
  bit            dmem_loaded;

  int            n_chk, n_pass;
  bit            last_dm;
  logic [DW-1:0] exp_if_rdata, exp_dm_rdata;

  mem_arb #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst_f(rst_f),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] seed(input int i);
    if (i == 16) return 32'h2100_0003;
    return (32'(i) * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
  endfunction

  // Synchronous memory: data for an access issued in cycle n is on mem_rdata in cycle n+1.
  always @(posedge clk) begin
    if (!dmem_loaded) begin
      for (int i = 0; i < 256; i++) dmem[i] <= seed(i);
      dmem_loaded <= 1'b1;
    end else if (mem_en && mem_we) begin
      dmem[mem_addr[7:0]] <= mem_wdata;
    end
    mem_rdata <= (mem_en && !mem_we) ? dmem[mem_addr[7:0]] : ($urandom() | 32'h1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ctl_vec();
    return 32'({if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we, busy});
  endfunction

  task automatic txn(input bit rq_if, input bit rq_dm, input logic [AW-1:0] ia, input bit we,
                     input logic [AW-1:0] da, input logic [DW-1:0] wd, input string tag);
    bit            first_dm;
    int            t_ig = -1, t_dg = -1, t_ir = -1, t_dr = -1;
    int            e_ig = -1, e_dg = -1, e_ir = -1, e_dr = -1;
    int            n_en = 0, bad_gate = 0, overlap = 0, hold_err = 0;
    logic [DW-1:0] e_if_val, e_dm_val;
    e_if_val = exp_if_rdata;
    e_dm_val = exp_dm_rdata;
    if (rq_if && rq_dm) begin
`ifdef MEM_ARB_RR_EN
      first_dm = !last_dm;
`else
      first_dm = 1'b1;
`endif
      last_dm = !first_dm;
    end else begin
      first_dm = rq_dm;
      last_dm  = rq_dm;
    end
    if (first_dm) begin
      e_dg = 1; e_dr = 1 + LAT;
      if (rq_if) begin e_ig = LAT + 3; e_ir = 2 * LAT + 3; end
    end else begin
      e_ig = 1; e_ir = 1 + LAT;
      if (rq_dm) begin e_dg = LAT + 3; e_dr = 2 * LAT + 3; end
    end
    if_req = rq_if; if_addr = ia;
    dm_req = rq_dm; dm_we = we; dm_addr = da; dm_wdata = wd;
    for (int t = 1; t <= RUN; t++) begin
      tick();
      if (mem_en) n_en++;
      if (!mem_en && (mem_we || mem_addr != '0 || mem_wdata != '0)) bad_gate++;
      if ((if_gnt && dm_gnt) || (if_rvalid && dm_rvalid)) overlap++;
      if (if_gnt) begin
        if (t_ig < 0) t_ig = t;
        chk({tag, "_if_mem_addr"}, 32'(mem_addr), 32'(ia));
        chk({tag, "_if_mem_we"}, 32'(mem_we), 32'd0);
        e_if_val = ref_mem[ia[7:0]];
        if_req = 1'b0; if_addr = 16'($urandom());
      end
      if (dm_gnt) begin
        if (t_dg < 0) t_dg = t;
        chk({tag, "_dm_mem_addr"}, 32'(mem_addr), 32'(da));
        chk({tag, "_dm_mem_we"}, 32'(mem_we), 32'(we));
        if (we) begin
          chk({tag, "_dm_mem_wdata"}, mem_wdata, wd);
          ref_mem[da[7:0]] = wd;
        end else begin
          e_dm_val = ref_mem[da[7:0]];
        end
        dm_req = 1'b0; dm_addr = 16'($urandom()); dm_wdata = $urandom(); dm_we = 1'($urandom());
      end
      if (if_rvalid) begin
        if (t_ir < 0) t_ir = t;
        exp_if_rdata = e_if_val;
      end
      if (dm_rvalid) begin
        if (t_dr < 0) t_dr = t;
        exp_dm_rdata = e_dm_val;
      end
      if (if_rdata !== exp_if_rdata || dm_rdata !== exp_dm_rdata) hold_err++;
    end
    chk({tag, "_if_gnt_cyc"}, 32'(t_ig), 32'(e_ig));
    chk({tag, "_dm_gnt_cyc"}, 32'(t_dg), 32'(e_dg));
    chk({tag, "_if_rvalid_cyc"}, 32'(t_ir), 32'(e_ir));
    chk({tag, "_dm_rvalid_cyc"}, 32'(t_dr), 32'(e_dr));
    chk({tag, "_mem_en_count"}, 32'(n_en), 32'(int'(rq_if) + int'(rq_dm)));
    chk({tag, "_gating"}, 32'(bad_gate), 32'd0);
    chk({tag, "_overlap"}, 32'(overlap), 32'd0);
    chk({tag, "_rdata_track"}, 32'(hold_err), 32'd0);
    chk({tag, "_if_rdata"}, if_rdata, e_if_val);
    chk({tag, "_dm_rdata"}, dm_rdata, e_dm_val);
    chk({tag, "_idle_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int cnt;
    n_chk = 0; n_pass = 0; last_dm = 1'b0;
    exp_if_rdata = '0; exp_dm_rdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = seed(i);
    rst_f = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;

    // Reset held for three cycles.
    tick();
    chk("rst_ctl", ctl_vec(), 32'd0);
    tick();
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_dm_rdata", dm_rdata, 32'd0);
    tick();
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst_f = 1'b1;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ctl_vec() != 32'd0) cnt++;
    end
    chk("idle_no_req", 32'(cnt), 32'd0);

    // Directed steps from the test plan.
    txn(1'b1, 1'b0, 16'h0010, 1'b0, 16'h0000, 32'h0, "fetch");
    chk("fetch_value", if_rdata, 32'h2100_0003);
    txn(1'b1, 1'b1, 16'h0020, 1'b0, 16'h0040, 32'h0, "tie1");
    txn(1'b0, 1'b1, 16'h0000, 1'b1, 16'h0080, 32'hDEAD_BEEF, "store");
    txn(1'b1, 1'b1, 16'h0080, 1'b0, 16'h0041, 32'h0, "tie2");

    // Request pulsed between edges is never sampled.
    if_req = 1'b1; if_addr = 16'h0055;
    #3;
    if_req = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (mem_en || busy) cnt++;
    end
    chk("pulse_no_access", 32'(cnt), 32'd0);

    // Reset during WAIT abandons the access.
    if_req = 1'b1; if_addr = 16'h0033;
    tick();
    chk("rw_gnt", 32'(if_gnt), 32'd1);
    if_req = 1'b0;
    tick();
    chk("rw_busy_wait", 32'(busy), 32'd1);
    rst_f = 1'b0;
    #1;
    chk("rw_ctl_in_rst", ctl_vec(), 32'd0);
    chk("rw_if_rdata_rst", if_rdata, 32'd0);
    exp_if_rdata = '0; exp_dm_rdata = '0; last_dm = 1'b0;
    tick();
    rst_f = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (if_rvalid || dm_rvalid || mem_en) cnt++;
    end
    chk("rw_no_rvalid", 32'(cnt), 32'd0);
    txn(1'b1, 1'b0, 16'h0010, 1'b0, 16'h0000, 32'h0, "post_rst");
    txn(1'b1, 1'b1, 16'h0011, 1'b0, 16'h0012, 32'h0, "post_rst_tie");

    // Random transactions.
    for (int n = 0; n < 40; n++) begin
      int combo;
      combo = $urandom_range(1, 3);
      txn(combo[0], combo[1], 16'($urandom()), 1'($urandom()), 16'($urandom()), $urandom(), "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
